// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    typedef enum logic {
        OWN_F,
        OWN_D
    } owner_t;

endpackage

// File: rtl/mem_arb_lat_cnt.sv
// Loadable down-counter that flags the last cycle of the memory wait window.
module mem_arb_lat_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // A count of 1 means this is the final wait cycle.
    assign done = (cnt <= W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between fetch (F) and ld/st (D) ports.
// Optional macro MEM_ARB_FAIR_EN forces an F grant after STARVE_MAX starving D grants.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LAT        = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_req,
    input  logic [WORD_W-1:0] f_addr,
    input  logic              f_flush,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [WORD_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [WORD_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [WORD_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [3:0] WAIT_LOAD = 4'(LAT - 1);

    state_t state;
    owner_t owner;
    logic   we_q;
    logic   cancel;
    logic   wait_done;
    logic   force_f;
    logic   idle;
    logic   resp;

    // Grants are combinational and gated by reset so every output is 0 in reset.
    assign idle  = rst_n && (state == IDLE);
    assign f_gnt = idle && f_req && !f_flush && (!d_req || force_f);
    assign d_gnt = idle && d_req && !f_gnt;

    assign resp     = (state == RESP);
    assign f_rvalid = resp && (owner == OWN_F) && !cancel && !f_flush;
    assign d_rvalid = resp && (owner == OWN_D);
    assign f_rdata  = f_rvalid ? mem_rdata : '0;
    assign d_rdata  = (d_rvalid && !we_q) ? mem_rdata : '0;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= OWN_F;
            we_q      <= 1'b0;
            cancel    <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            case (state)
                IDLE: begin
                    cancel <= 1'b0;
                    if (f_gnt || d_gnt) begin
                        state     <= ISSUE;
                        owner     <= d_gnt ? OWN_D : OWN_F;
                        we_q      <= d_gnt && d_we;
                        mem_en    <= 1'b1;
                        mem_we    <= d_gnt && d_we;
                        mem_addr  <= d_gnt ? d_addr : f_addr;
                        mem_wdata <= d_gnt ? d_wdata : '0;
                    end
                end
                ISSUE: begin
                    if (owner == OWN_F && f_flush) cancel <= 1'b1;
                    state <= (LAT == 1) ? RESP : WAIT;
                end
                WAIT: begin
                    if (owner == OWN_F && f_flush) cancel <= 1'b1;
                    if (wait_done) state <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    mem_arb_lat_cnt #(.W(4)) u_lat_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state == ISSUE),
        .load_val (WAIT_LOAD),
        .en       (state == WAIT),
        .done     (wait_done)
    );

`ifdef MEM_ARB_FAIR_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic [SW-1:0] starve;

    // Counts D grants that bypassed a live fetch; saturates at STARVE_MAX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve <= '0;
        end else if (f_gnt || !f_req) begin
            starve <= '0;
        end else if (d_gnt && !f_flush && starve != SW'(STARVE_MAX)) begin
            starve <= starve + 1'b1;
        end
    end

    assign force_f = (starve == SW'(STARVE_MAX));
`else
    logic unused_starve;
    assign unused_starve = (STARVE_MAX == 0);
    assign force_f       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-timing model.
module tb_mem_port_arbiter;

    localparam int LAT        = 2;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        f_req = 1'b0, f_flush = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [15:0] f_addr = '0, d_addr = '0, d_wdata = '0;
    logic        f_gnt, f_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
    logic [15:0] f_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.LAT(LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_flush(f_flush), .f_gnt(f_gnt),
        .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    // Memory model: read data appears LAT cycles after the mem_en cycle, garbage otherwise.
    logic [15:0] mem [65536];
    logic [15:0] ref_mem [65536];
    logic [15:0] rd_pipe [LAT];

    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        rd_pipe[0] <= mem_en ? mem[mem_addr] : 16'($urandom);
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[LAT-1];

    int n_cmp = 0, n_bad = 0, cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // Reference model: one outstanding transaction, described by its grant cycle.
    bit          t_act = 0, t_own_d = 0, t_we = 0, t_cancel = 0;
    logic [15:0] t_addr = '0, t_wdata = '0, t_rdata = '0;
    int          t_gcyc = 0, starve = 0;
    bit          last_fg = 0, last_dg = 0, f_cont = 0, d_cont = 0, count_fair = 0;
    int          fair_f_model = 0, fair_f_dut = 0;

    task automatic eval_cycle();
        int          ph;
        bit          efg, edg, force_f, e_fv, e_dv, e_men, e_mwe, e_busy;
        logic [15:0] e_fr, e_dr, e_ma, e_mw;
        {efg, edg, force_f, e_fv, e_dv, e_men, e_mwe, e_busy} = '0;
        {e_fr, e_dr, e_ma, e_mw} = '0;
        ph = cyc - t_gcyc;
        if (rst_n) begin
            if (t_act && !t_own_d && f_flush) t_cancel = 1;
            if (t_act) begin
                e_busy = 1;
                if (ph == 1) begin
                    e_men = 1; e_mwe = t_we; e_ma = t_addr; e_mw = t_wdata;
                end
                if (ph == LAT + 1) begin
                    if (t_own_d) begin
                        e_dv = 1; e_dr = t_we ? 16'h0 : t_rdata;
                    end else if (!t_cancel) begin
                        e_fv = 1; e_fr = t_rdata;
                    end
                end
            end else begin
`ifdef MEM_ARB_FAIR_EN
                force_f = (starve >= STARVE_MAX);
`endif
                if (f_req && !f_flush && (!d_req || force_f)) efg = 1;
                else if (d_req) edg = 1;
            end
        end
        check_eq("f_gnt", 32'(f_gnt), 32'(efg));
        check_eq("d_gnt", 32'(d_gnt), 32'(edg));
        check_eq("f_rvalid", 32'(f_rvalid), 32'(e_fv));
        check_eq("f_rdata", 32'(f_rdata), 32'(e_fr));
        check_eq("d_rvalid", 32'(d_rvalid), 32'(e_dv));
        check_eq("d_rdata", 32'(d_rdata), 32'(e_dr));
        check_eq("mem_en", 32'(mem_en), 32'(e_men));
        check_eq("mem_we", 32'(mem_we), 32'(e_mwe));
        check_eq("mem_addr", 32'(mem_addr), 32'(e_ma));
        check_eq("mem_wdata", 32'(mem_wdata), 32'(e_mw));
        check_eq("busy", 32'(busy), 32'(e_busy));
        if (rst_n) begin
            if (t_act && ph == LAT + 1) t_act = 0;
            if (efg || edg) begin
                t_act = 1; t_gcyc = cyc; t_cancel = 0; t_own_d = edg;
                t_we = edg && d_we;
                t_addr = edg ? d_addr : f_addr;
                t_wdata = edg ? d_wdata : 16'h0;
                t_rdata = ref_mem[t_addr];
                if (t_we) ref_mem[t_addr] = d_wdata;
            end
            if (efg || !f_req) starve = 0;
            else if (edg && !f_flush && starve < STARVE_MAX) starve++;
            if (count_fair && efg) fair_f_model++;
            if (count_fair && f_gnt) fair_f_dut++;
        end
        last_fg = efg;
        last_dg = edg;
    endtask

    task automatic new_d();
        d_we = 1'($urandom_range(0, 1));
        d_addr = 16'($urandom_range(0, 255));
        d_wdata = 16'($urandom);
    endtask

    task automatic tick();
        @(negedge clk);
        eval_cycle();
        @(posedge clk);
        #1;
        cyc++;
        if (f_req && last_fg) begin
            if (f_cont) f_addr = 16'($urandom_range(0, 255));
            else f_req = 0;
        end
        if (d_req && last_dg) begin
            if (d_cont) new_d();
            else d_req = 0;
        end
    endtask

    task automatic wait_quiet();
        for (int i = 0; i < 40 && (t_act || f_req || d_req); i++) tick();
        check_eq("quiet", 32'(t_act || f_req || d_req), 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            logic [15:0] v;
            v = 16'($urandom);
            mem[i] <= v;
            ref_mem[i] = v;
        end
        mem[16'h0010] <= 16'h8123; ref_mem[16'h0010] = 16'h8123;
        mem[16'h0200] <= 16'h4a5c; ref_mem[16'h0200] = 16'h4a5c;
        repeat (3) tick();
        rst_n = 1;
        repeat (2) tick();

        // Fetch read
        f_req = 1; f_addr = 16'h0010;
        repeat (6) tick();
        // Simultaneous F and D
        wait_quiet();
        f_req = 1; f_addr = 16'h0040;
        d_req = 1; d_we = 0; d_addr = 16'h0200; d_wdata = 16'h1111;
        repeat (10) tick();
        // Store then load it back
        wait_quiet();
        d_req = 1; d_we = 1; d_addr = 16'h0300; d_wdata = 16'hbeef;
        repeat (5) tick();
        d_req = 1; d_we = 0; d_addr = 16'h0300;
        repeat (5) tick();
        // Flush an in-flight fetch two cycles after its grant
        wait_quiet();
        f_req = 1; f_addr = 16'h0020;
        tick();
        tick();
        f_flush = 1; f_req = 1; f_addr = 16'h0030;
        tick();
        f_flush = 0;
        repeat (6) tick();
        // Reset during WAIT, with a D request pending
        wait_quiet();
        f_req = 1; f_addr = 16'h0044;
        tick();
        tick();
        d_req = 1; d_we = 0; d_addr = 16'h0050;
        #2;
        rst_n = 0;
        #1;
        eval_cycle();
        t_act = 0; starve = 0;
        repeat (2) tick();
        rst_n = 1;
        repeat (6) tick();
        // Continuous contention
        wait_quiet();
        count_fair = 1; f_cont = 1; d_cont = 1;
        f_req = 1; f_addr = 16'h0060; d_req = 1; new_d();
        repeat (40) tick();
        count_fair = 0; f_cont = 0; d_cont = 0;
        check_eq("fair_f_gnts", 32'(fair_f_dut), 32'(fair_f_model));
        f_req = 0; d_req = 0;
        wait_quiet();
        // Random traffic with flushes
        for (int n = 0; n < 600; n++) begin
            if (!f_req && $urandom_range(0, 3) == 0) begin
                f_req = 1; f_addr = 16'($urandom_range(0, 255));
            end
            if (!d_req && $urandom_range(0, 3) == 0) begin
                d_req = 1; new_d();
            end
            f_flush = ($urandom_range(0, 7) == 0);
            tick();
        end
        f_flush = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the CPU's single-ported 16-bit memory between the fetch stage (F port) and the ld/st execute stage (D port). Accepts one transaction at a time, drives the memory port with registered signals, waits a fixed read latency, then returns data or a completion to the owner. Also discards fetch responses cancelled by a taken jump. It sits between the pipeline and the memory model; the pipeline's mem_addr/mem_data for st come from the D port of this block.

Parameters:
LAT, 2, memory read latency in cycles from the mem_en cycle to a valid mem_rdata; legal range 1..15
STARVE_MAX, 4, consecutive D grants with f_req pending before F is forced; used only with the optional feature

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
f_req  in  1  fetch request; held with f_addr stable until f_gnt
f_addr  in  16  fetch word address
f_flush  in  1  jump taken; cancels the pending or in-flight fetch
f_gnt  out  1  fetch accepted this cycle
f_rvalid  out  1  fetch data valid, one-cycle pulse
f_rdata  out  16  fetch data; 0 when f_rvalid=0
d_req  in  1  ld/st request; held with d_we/d_addr/d_wdata stable until d_gnt
d_we  in  1  1=st, 0=ld
d_addr  in  16  data word address
d_wdata  in  16  store data
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  ld data valid or st complete, one-cycle pulse
d_rdata  out  16  ld data; 0 for st and when d_rvalid=0
mem_en  out  1  memory access strobe, registered
mem_we  out  1  memory write enable, registered
mem_addr  out  16  memory address, registered
mem_wdata  out  16  memory write data, registered
mem_rdata  in  16  memory read data, valid LAT cycles after mem_en
busy  out  1  1 in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; every output is 0; the latency counter, owner, cancel flag and starvation counter are cleared. Reset in mid-transaction drops the in-flight transaction with no rvalid. mem_en is 0 from the reset assertion onward.
- States:
  - IDLE: arbitrates.
  - ISSUE: one cycle; mem_en=1 with the captured address, data and we.
  - WAIT: LAT-1 cycles, counted by a down-counter.
  - RESP: one cycle; the owner's rvalid=1 and rdata=mem_rdata (gated to 0 for st).
  - RESP always returns to IDLE.
- Grants are combinational and are given only in IDLE.
  - d_req wins over f_req.
  - f_gnt is suppressed when f_flush=1 in the same cycle.
  - At most one grant per cycle.
- Accept at cycle T:
  - ISSUE at T+1.
  - RESP at T+1+LAT.
  - The earliest next grant is at T+LAT+2.
- The owner, address, we and wdata are captured at grant. The memory outputs are registered from that capture and are held 0 outside ISSUE.
- Flush:
  - If f_flush=1 while a fetch is in ISSUE, WAIT or RESP, a cancel flag is set (or applies immediately in RESP).
  - The memory access still completes, but f_rvalid is not asserted.
  - f_flush has no effect on D transactions.
- The st completion pulse d_rvalid fires in RESP like ld, with d_rdata=0.
- An F or D response is never issued without a matching grant.
- The two rvalid outputs are never high together.

Optional Feature:
MEM_ARB_FAIR_EN
- Defined:
  - A saturating counter increments on each d_gnt issued while f_req=1 and f_flush=0.
  - When the counter equals STARVE_MAX, the next IDLE arbitration grants F even if d_req=1.
  - The counter clears on any f_gnt or when f_req=0.
- Undefined: strict D-over-F priority, and the counter logic is absent.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP);
  - the owner enum (OWN_F, OWN_D);
  - the 16-bit word width constant.
- One natural sub-module, mem_arb_lat_cnt: a loadable down-counter with a done flag, used for WAIT.

Test Plan (LAT=2):
1. Fetch read:
   - Stimulus: f_req, f_addr=0x0010, mem returns 0x8123.
   - Response: f_gnt at T; mem_en/mem_addr=0x0010 at T+1; f_rvalid with f_rdata=0x8123 at T+3; busy low at T+4.
2. Simultaneous requests:
   - Stimulus: f_req and d_req (ld 0x0200) in IDLE.
   - Response: d_gnt first; d_rvalid at T+3; f_gnt at T+4; f_rvalid at T+7.
3. Store:
   - Stimulus: d_we=1, d_addr=0x0300, d_wdata=0xBEEF.
   - Response: mem_we=1, mem_addr=0x0300, mem_wdata=0xBEEF at T+1; d_rvalid at T+3 with d_rdata=0.
4. Flush:
   - Stimulus: fetch granted at T, f_flush pulse at T+2.
   - Response: mem_en still at T+1; no f_rvalid at T+3; next f_gnt possible at T+4.
5. Reset mid-operation:
   - Stimulus: rst_n low during WAIT.
   - Response: all outputs 0 immediately; no rvalid afterwards; a new request after release is served normally.
6. Fairness (MEM_ARB_FAIR_EN, STARVE_MAX=4):
   - Stimulus: continuous d_req and f_req.
   - Response: 4 D grants, then 1 F grant, repeating; without the macro, F is never granted.
